// File: rtl/synapse_pkg.sv
// -----------------------------------------------------------------------------
// synapse_pkg
// Shared definitions for the synapse array: MAC FSM state encodings and the
// width helpers that derive trace and weighted-sum widths from parameters.
// -----------------------------------------------------------------------------
package synapse_pkg;

    // MAC pass state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SNAP = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Trace is one bit wider than the base width parameter
    function automatic int trace_width(input int p_width);
        return p_width + 1;
    endfunction

    // Product width plus enough headroom to sum every channel without overflow
    function automatic int sum_width(input int p_width, input int p_weight_width,
                                     input int p_channels);
        return trace_width(p_width) + p_weight_width + $clog2(p_channels);
    endfunction

endpackage

// File: rtl/synapse_channel.sv
// -----------------------------------------------------------------------------
// synapse_channel
// One synapse channel: 2-flop synchronizer, registered rising-edge detector and
// a decaying trace register. A spike loads the trace with its maximum value;
// a decay tick removes trace>>shift (at least 1) without going below zero.
// Ports:
//   i_clk   - clock
//   i_rst   - synchronous active-high reset
//   i_event - asynchronous spike input
//   i_tick  - one-cycle decay tick from the shared prescaler
//   o_tr    - current trace value (register output)
// -----------------------------------------------------------------------------
module synapse_channel
    import synapse_pkg::*;
#(
    parameter int P_TW          = 10,
    parameter int P_DECAY_SHIFT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_event,
    input  logic            i_tick,
    output logic [P_TW-1:0] o_tr
);

    localparam logic [P_TW-1:0] LP_TMAX = {P_TW{1'b1}};
    localparam logic [P_TW-1:0] LP_ONE  = P_TW'(1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic            r_spike;
    logic [P_TW-1:0] r_tr;
    logic [P_TW-1:0] w_dec;
    logic [P_TW-1:0] w_tr_nxt;

    // Next trace value: spike has priority over decay, decay floors at zero
    always_comb begin
        w_dec    = r_tr >> P_DECAY_SHIFT;
        w_tr_nxt = r_tr;
        if (r_spike) begin
            w_tr_nxt = LP_TMAX;
        end else if (i_tick) begin
            if (w_dec != '0) begin
                w_tr_nxt = r_tr - w_dec;
            end else if (r_tr != '0) begin
                w_tr_nxt = r_tr - LP_ONE;
            end else begin
                w_tr_nxt = '0;
            end
        end else begin
            w_tr_nxt = r_tr;
        end
    end

    // Synchronizer, registered edge detect and trace state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_spike <= 1'b0;
            r_tr    <= '0;
        end else begin
            r_sync1 <= i_event;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_spike <= r_sync2 & ~r_prev;
            r_tr    <= w_tr_nxt;
        end
    end

    assign o_tr = r_tr;

endmodule

// File: rtl/synapse_array.sv
// -----------------------------------------------------------------------------
// synapse_array
// P_CHANNELS decaying synapse traces, a shared decay prescaler, a small weight
// register file and a sequential MAC that computes sum(trace[i] * weight[i])
// over a snapshot of the traces, one channel per cycle.
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_event             - per-channel asynchronous spike inputs
//   i_decay_period      - decay tick period minus one (0 = every cycle)
//   i_wr_en/addr/data   - weight write port (out-of-range addresses ignored)
//   i_enable            - allows MAC passes to start
//   o_tr                - packed traces, channel 0 in LSBs
//   o_sum, o_sum_valid  - result of last completed pass, one-cycle valid pulse
//   o_busy              - high while a MAC pass is in progress
// -----------------------------------------------------------------------------
module synapse_array
    import synapse_pkg::*;
#(
    parameter int P_CHANNELS     = 4,
    parameter int P_WIDTH        = 9,
    parameter int P_WEIGHT_WIDTH = 9,
    parameter int P_DECAY_SHIFT  = 4
) (
    input  logic                                                            i_clk,
    input  logic                                                            i_rst,
    input  logic [P_CHANNELS-1:0]                                           i_event,
    input  logic [7:0]                                                      i_decay_period,
    input  logic                                                            i_wr_en,
    input  logic [$clog2(P_CHANNELS)-1:0]                                   i_wr_addr,
    input  logic signed [P_WEIGHT_WIDTH-1:0]                                i_wr_data,
    input  logic                                                            i_enable,
    output logic [P_CHANNELS*trace_width(P_WIDTH)-1:0]                      o_tr,
    output logic signed [sum_width(P_WIDTH, P_WEIGHT_WIDTH, P_CHANNELS)-1:0] o_sum,
    output logic                                                            o_sum_valid,
    output logic                                                            o_busy
);

    localparam int LP_TW = trace_width(P_WIDTH);
    localparam int LP_WW = P_WEIGHT_WIDTH;
    localparam int LP_AW = $clog2(P_CHANNELS);
    localparam int LP_SW = sum_width(P_WIDTH, P_WEIGHT_WIDTH, P_CHANNELS);
    localparam int LP_PW = LP_TW + LP_WW;

    // One extra bit so the channel count itself is representable
    localparam logic [LP_AW:0]   LP_CH_LIM   = (LP_AW + 1)'(P_CHANNELS);
    localparam logic [LP_AW-1:0] LP_LAST_IDX = LP_AW'(P_CHANNELS - 1);
    localparam logic [LP_AW-1:0] LP_IDX_ONE  = LP_AW'(1);
    localparam logic [7:0]       LP_PS_ONE   = 8'd1;

    // ---------------------------------------------------------------- decay
    logic [7:0] r_presc;
    logic [7:0] r_period;
    logic       w_tick;

    assign w_tick = (r_presc == r_period);

    // Prescaler; the period input is only sampled at wrap so a change never
    // truncates or stretches the running interval
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc  <= 8'd0;
            r_period <= 8'd0;
        end else if (w_tick) begin
            r_presc  <= 8'd0;
            r_period <= i_decay_period;
        end else begin
            r_presc  <= r_presc + LP_PS_ONE;
        end
    end

    // ------------------------------------------------------------- channels
    logic [P_CHANNELS-1:0][LP_TW-1:0] w_tr;

    for (genvar g = 0; g < P_CHANNELS; g++) begin : g_ch
        synapse_channel #(
            .P_TW          (LP_TW),
            .P_DECAY_SHIFT (P_DECAY_SHIFT)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_event (i_event[g]),
            .i_tick  (w_tick),
            .o_tr    (w_tr[g])
        );
    end

    assign o_tr = w_tr;

    // -------------------------------------------------------------- weights
    logic signed [LP_WW-1:0] r_weight [P_CHANNELS];

    // Weight register file; same-cycle readers see the pre-write value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < P_CHANNELS; i++) begin
                r_weight[i] <= '0;
            end
        end else if (i_wr_en && ({1'b0, i_wr_addr} < LP_CH_LIM)) begin
            r_weight[i_wr_addr] <= i_wr_data;
        end else begin
            for (int i = 0; i < P_CHANNELS; i++) begin
                r_weight[i] <= r_weight[i];
            end
        end
    end

    // ------------------------------------------------------------------ MAC
    logic [1:0]                       r_state;
    logic [1:0]                       w_state_nxt;
    logic [LP_AW-1:0]                 r_idx;
    logic [P_CHANNELS-1:0][LP_TW-1:0] r_snap;
    logic signed [LP_SW-1:0]          r_acc;
    logic signed [LP_SW-1:0]          r_sum;
    logic                             r_sum_valid;
    logic                             r_busy;
    logic [LP_TW-1:0]                 w_snap_sel;
    logic signed [LP_WW-1:0]          w_weight_sel;
    logic signed [LP_PW-1:0]          w_prod;
    logic signed [LP_SW-1:0]          w_prod_ext;

    // Current product: unsigned trace zero-extended, weight sign-extended,
    // both to the full product width so nothing is truncated
    always_comb begin
        w_snap_sel   = r_snap[r_idx];
        w_weight_sel = r_weight[r_idx];
        w_prod       = $signed({{LP_WW{1'b0}}, w_snap_sel})
                     * $signed({{LP_TW{w_weight_sel[LP_WW-1]}}, w_weight_sel});
        w_prod_ext   = {{(LP_SW - LP_PW){w_prod[LP_PW-1]}}, w_prod};
    end

    // FSM next-state: a pass always runs to DONE once started
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_state_nxt = ST_SNAP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SNAP: w_state_nxt = ST_ACC;
            ST_ACC: begin
                if (r_idx == LP_LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_DONE: begin
                if (i_enable) begin
                    w_state_nxt = ST_SNAP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, datapath registers and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_snap      <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_sum_valid <= 1'b0;
            case (r_state)
                ST_SNAP: begin
                    r_snap <= w_tr;
                    r_acc  <= '0;
                    r_idx  <= '0;
                end
                ST_ACC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_idx != LP_LAST_IDX) begin
                        r_idx <= r_idx + LP_IDX_ONE;
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                ST_DONE: begin
                    r_sum       <= r_acc;
                    r_sum_valid <= 1'b1;
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign o_sum       = r_sum;
    assign o_sum_valid = r_sum_valid;
    assign o_busy      = r_busy;

endmodule
